// File: rtl/dsp_lane_accum.sv
// rtl/dsp_lane_accum.sv - four-lane reduction and 2**LOG2_N-frame block accumulator with a one-entry output buffer
// Define DSP_LANE_ACCUM_AVG_EN to report the truncated block average instead of the block sum.
module dsp_lane_accum #(
  parameter int LANE_W = 13,
  parameter int LOG2_N = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [LANE_W-1:0]          IN1,
  input  logic [LANE_W-1:0]          IN2,
  input  logic [LANE_W-1:0]          IN3,
  input  logic [LANE_W-1:0]          IN4,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic                       CLR,
  output logic [LANE_W+LOG2_N+1:0]   ACC_OUT,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [LOG2_N-1:0]          FRM_CNT
);

  localparam int ACC_W = LANE_W + 2 + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_CNT = '1;

  logic [LANE_W:0]  p0;
  logic [LANE_W:0]  p1;
  logic             s1_valid;
  logic             s1_last;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] result;
  logic             accept;
  logic             load;

  assign IN_READY = ~OUT_VALID | OUT_READY;
  assign accept   = IN_VALID & IN_READY;
  assign sum      = acc + ACC_W'(p0) + ACC_W'(p1);
  // CLR wipes the in-flight frame as well, so a block cut short can never report.
  assign load     = s1_valid & s1_last & ~CLR;

`ifdef DSP_LANE_ACCUM_AVG_EN
  assign result = sum >> LOG2_N;
`else
  assign result = sum;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      p0       <= '0;
      p1       <= '0;
      FRM_CNT  <= '0;
    end else if (CLR) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      FRM_CNT  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        p0      <= {1'b0, IN1} + {1'b0, IN2};
        p1      <= {1'b0, IN3} + {1'b0, IN4};
        s1_last <= (FRM_CNT == LAST_CNT);
        FRM_CNT <= FRM_CNT + LOG2_N'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      acc <= '0;
    end else if (CLR || load) begin
      acc <= '0;
    end else if (s1_valid) begin
      acc <= sum;
    end
  end

  // A new result may load on the same edge the previous one is consumed.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ACC_OUT   <= '0;
      OUT_VALID <= 1'b0;
    end else if (load) begin
      ACC_OUT   <= result;
      OUT_VALID <= 1'b1;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsp_lane_accum.sv
// tb/tb_dsp_lane_accum.sv - directed and randomized bench for dsp_lane_accum against a frame-level model
module tb_dsp_lane_accum;

  localparam int N = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [12:0] IN1 = '0, IN2 = '0, IN3 = '0, IN4 = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic        CLR = 1'b0;
  logic [17:0] ACC_OUT;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [2:0]  FRM_CNT;

  dsp_lane_accum dut (
    .CLK(CLK), .RST(RST), .IN1(IN1), .IN2(IN2), .IN3(IN3), .IN4(IN4),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .CLR(CLR), .ACC_OUT(ACC_OUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FRM_CNT(FRM_CNT)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Frame-level reference: count frames per block, sum them, and expose the
  // block result on the clock after its last frame is taken.
  bit          checking = 1'b0;
  bit          exp_ov = 1'b0;
  longint      exp_acc = 0;
  int          exp_cnt = 0;
  longint      blk_sum = 0;
  bit          land_pending = 1'b0;
  longint      land_val = 0;
  logic [17:0] got[$];

  function automatic longint res(longint s);
`ifdef DSP_LANE_ACCUM_AVG_EN
    return s / N;
`else
    return s;
`endif
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(output bit took);
    bit acc_ok;
    bit hs;
    @(negedge CLK);
    if (checking) begin
      chk("out_valid", {63'd0, OUT_VALID}, {63'd0, exp_ov});
      if (exp_ov) chk("acc_out", {46'd0, ACC_OUT}, exp_acc);
      chk("frm_cnt", {61'd0, FRM_CNT}, exp_cnt);
      chk("in_ready", {63'd0, IN_READY}, {63'd0, (!exp_ov || OUT_READY)});
    end
    acc_ok = IN_VALID && (!exp_ov || OUT_READY);
    hs     = exp_ov && OUT_READY;
    if (hs && RST) got.push_back(ACC_OUT);
    @(posedge CLK);
    #1;
    took = acc_ok && RST && !CLR;
    if (!RST) begin
      exp_ov = 0; exp_acc = 0; exp_cnt = 0; blk_sum = 0; land_pending = 0;
    end else begin
      if (hs) exp_ov = 0;
      if (land_pending && !CLR) begin
        exp_ov  = 1;
        exp_acc = land_val;
      end
      land_pending = 0;
      if (CLR) begin
        exp_cnt = 0; blk_sum = 0;
      end else if (acc_ok) begin
        blk_sum += longint'(IN1) + longint'(IN2) + longint'(IN3) + longint'(IN4);
        exp_cnt++;
        if (exp_cnt == N) begin
          land_pending = 1; land_val = res(blk_sum); blk_sum = 0; exp_cnt = 0;
        end
      end
    end
  endtask

  task automatic send(logic [12:0] v);
    bit took = 0;
    IN1 = v; IN2 = v; IN3 = v; IN4 = v; IN_VALID = 1;
    for (int i = 0; i < 50 && !took; i++) step(took);
    if (!took) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(int n);
    bit t;
    IN_VALID = 0;
    for (int i = 0; i < n; i++) step(t);
  endtask

  initial begin
    bit t;
    // Reset hold with IN_VALID asserted
    RST = 0; IN_VALID = 1; IN1 = 5; IN2 = 5; IN3 = 5; IN4 = 5;
    for (int i = 0; i < 3; i++) step(t);
    chk("rst_out_valid", {63'd0, OUT_VALID}, 0);
    chk("rst_acc_out", {46'd0, ACC_OUT}, 0);
    chk("rst_frm_cnt", {61'd0, FRM_CNT}, 0);
    chk("rst_in_ready", {63'd0, IN_READY}, 1);
    RST = 1; IN_VALID = 0; checking = 1;

    // Single block
    got.delete();
    for (int i = 0; i < N; i++) send(13'd1024);
    idle(3);
    chk("blk1_count", got.size(), 1);
    if (got.size() >= 1) chk("blk1_val", {46'd0, got[0]}, res(32768));

    // Back-to-back blocks without a gap
    got.delete();
    for (int i = 0; i < N; i++) send(13'd1024);
    for (int i = 0; i < N; i++) send(13'd4040);
    idle(4);
    chk("b2b_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("b2b_val0", {46'd0, got[0]}, res(32768));
      chk("b2b_val1", {46'd0, got[1]}, res(129280));
    end

    // Backpressure on the first result
    got.delete();
    OUT_READY = 0;
    for (int i = 0; i < N; i++) send(13'd100);
    idle(6);
    chk("bp_in_ready", {63'd0, IN_READY}, 0);
    chk("bp_held", {46'd0, ACC_OUT}, res(3200));
    OUT_READY = 1;
    for (int i = 0; i < N; i++) send(13'd200);
    idle(4);
    chk("bp_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("bp_val0", {46'd0, got[0]}, res(3200));
      chk("bp_val1", {46'd0, got[1]}, res(6400));
    end

    // CLR discards a partial block
    got.delete();
    for (int i = 0; i < 3; i++) send(13'd20);
    IN_VALID = 0; CLR = 1;
    step(t);
    CLR = 0;
    chk("clr_frm_cnt", {61'd0, FRM_CNT}, 0);
    for (int i = 0; i < N; i++) send(13'd2230);
    idle(3);
    chk("clr_count", got.size(), 1);
    if (got.size() >= 1) chk("clr_val", {46'd0, got[0]}, res(71360));

    // Full-scale lanes
    got.delete();
    for (int i = 0; i < N; i++) send(13'd8191);
    idle(3);
    chk("max_count", got.size(), 1);
    if (got.size() >= 1) chk("max_val", {46'd0, got[0]}, res(262112));

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      IN_VALID  = ($urandom % 4) != 0;
      IN1 = 13'($urandom); IN2 = 13'($urandom); IN3 = 13'($urandom); IN4 = 13'($urandom);
      OUT_READY = ($urandom % 3) != 0;
      step(t);
    end
    OUT_READY = 1;
    idle(4);
    chk("drain_out_valid", {63'd0, OUT_VALID}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
